// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - issue/resolution bundle between the odd pipe and branch_resolve
//
// Issue side (driven by the odd pipe):
//   in_valid, in_op, in_pc, in_imm, in_ra, in_rt, in_rt_addr, in_pred_taken, in_pred_pc
// Resolution side (driven by branch_resolve):
//   PCout (66-bit feedback word), flush, lnk_we/lnk_addr/lnk_data, br_count, mp_count
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic [0:2]        in_op;
  logic [0:31]       in_pc;
  logic [0:15]       in_imm;
  logic [0:31]       in_ra;
  logic [0:31]       in_rt;
  logic [0:6]        in_rt_addr;
  logic              in_pred_taken;
  logic [0:31]       in_pred_pc;

  logic [0:65]       PCout;
  logic              flush;
  logic              lnk_we;
  logic [0:6]        lnk_addr;
  logic [0:31]       lnk_data;
  logic [0:CNT_W-1]  br_count;
  logic [0:CNT_W-1]  mp_count;

  modport master (
    output in_valid, in_op, in_pc, in_imm, in_ra, in_rt, in_rt_addr, in_pred_taken, in_pred_pc,
    input  PCout, flush, lnk_we, lnk_addr, lnk_data, br_count, mp_count
  );

  modport slave (
    input  in_valid, in_op, in_pc, in_imm, in_ra, in_rt, in_rt_addr, in_pred_taken, in_pred_pc,
    output PCout, flush, lnk_we, lnk_addr, lnk_data, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - odd-pipe branch resolution: target/condition eval, mispredict, link write
//
// Ports:
//   clk    - single clock
//   reset  - synchronous, active-high
//   br     - branch_resolve_if.slave: issued branch + fetch prediction in,
//            PCout {next_pc, taken, pc, mispredict}, flush, link write and
//            saturating branch/mispredict counters out
//
// Two stages: E1 registers the issued branch, E2 evaluates it and registers
// the results, so a branch issued in cycle N is reported in cycle N+2.
module branch_resolve #(
  parameter logic [0:31] LSLR  = 32'h0003_FFFC,
  parameter int          CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  branch_resolve_if.slave br
);

  localparam logic [0:2] OP_BR    = 3'd0;
  localparam logic [0:2] OP_BRA   = 3'd1;
  localparam logic [0:2] OP_BI    = 3'd2;
  localparam logic [0:2] OP_BRZ   = 3'd3;
  localparam logic [0:2] OP_BRNZ  = 3'd4;
  localparam logic [0:2] OP_BRHZ  = 3'd5;
  localparam logic [0:2] OP_BRHNZ = 3'd6;
  localparam logic [0:2] OP_BRSL  = 3'd7;

  // E1 stage
  logic        e1_valid;
  logic [0:2]  e1_op;
  logic [0:31] e1_pc;
  logic [0:15] e1_imm;
  logic [0:31] e1_ra;
  logic [0:31] e1_rt;
  logic [0:6]  e1_rt_addr;
  logic        e1_pred_taken;
  logic [0:31] e1_pred_pc;

  // E2 output registers
  logic [0:65]      pcout_q;
  logic             flush_q;
  logic             lnk_we_q;
  logic [0:6]       lnk_addr_q;
  logic [0:31]      lnk_data_q;
  logic [0:CNT_W-1] br_cnt_q;
  logic [0:CNT_W-1] mp_cnt_q;

  // E2 combinational evaluation
  logic [0:31] word_off;
  logic [0:31] fall_thru;
  logic [0:31] target;
  logic        taken;
  logic [0:31] next_pc;
  logic        mispredict;
  logic        resolve;
  logic        is_brsl;

  // flush_q is high exactly while the mispredicting word is on PCout, which is
  // the cycle the younger E1 entry and any new issue must be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      e1_valid <= 1'b0;
    end else begin
      e1_valid <= br.in_valid & ~flush_q;
    end
    e1_op         <= br.in_op;
    e1_pc         <= br.in_pc;
    e1_imm        <= br.in_imm;
    e1_ra         <= br.in_ra;
    e1_rt         <= br.in_rt;
    e1_rt_addr    <= br.in_rt_addr;
    e1_pred_taken <= br.in_pred_taken;
    e1_pred_pc    <= br.in_pred_pc;
  end

  always_comb begin
    word_off  = {{14{e1_imm[0]}}, e1_imm, 2'b00};
    fall_thru = (e1_pc + 32'd4) & LSLR;
    target    = (e1_pc + word_off) & LSLR;
    taken     = 1'b1;
    case (e1_op)
      OP_BRA:   target = word_off & LSLR;
      OP_BI:    target = e1_ra & LSLR;
      default:  target = (e1_pc + word_off) & LSLR;
    endcase
    case (e1_op)
      OP_BRZ:   taken = (e1_rt == 32'd0);
      OP_BRNZ:  taken = (e1_rt != 32'd0);
      OP_BRHZ:  taken = (e1_rt[16:31] == 16'd0);
      OP_BRHNZ: taken = (e1_rt[16:31] != 16'd0);
      default:  taken = 1'b1;
    endcase
    next_pc    = taken ? target : fall_thru;
    // pred_pc only matters when both sides agree the branch is taken
    mispredict = (taken != e1_pred_taken) | (taken & e1_pred_taken & (target != e1_pred_pc));
    resolve    = e1_valid & ~flush_q;
    is_brsl    = (e1_op == OP_BRSL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcout_q    <= '0;
      flush_q    <= 1'b0;
      lnk_we_q   <= 1'b0;
      lnk_addr_q <= '0;
      lnk_data_q <= '0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      pcout_q    <= '0;
      flush_q    <= 1'b0;
      lnk_we_q   <= 1'b0;
      lnk_addr_q <= '0;
      lnk_data_q <= '0;
      if (resolve) begin
        pcout_q <= {next_pc, taken, e1_pc, mispredict};
        flush_q <= mispredict;
        if (is_brsl) begin
          lnk_we_q   <= 1'b1;
          lnk_addr_q <= e1_rt_addr;
          lnk_data_q <= fall_thru;
        end
        if (!(&br_cnt_q)) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (mispredict && !(&mp_cnt_q)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign br.PCout    = pcout_q;
  assign br.flush    = flush_q;
  assign br.lnk_we   = lnk_we_q;
  assign br.lnk_addr = lnk_addr_q;
  assign br.lnk_data = lnk_data_q;
  assign br.br_count = br_cnt_q;
  assign br.mp_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;

  branch_resolve_if #(.CNT_W(CNT_W)) bif();
  branch_resolve #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .br(bif));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.in_valid      = 1'b0;
    bif.in_op         = 3'd0;
    bif.in_pc         = 32'd0;
    bif.in_imm        = 16'd0;
    bif.in_ra         = 32'd0;
    bif.in_rt         = 32'd0;
    bif.in_rt_addr    = 7'd0;
    bif.in_pred_taken = 1'b0;
    bif.in_pred_pc    = 32'd0;
  endtask

  task automatic issue(input logic [0:2] op, input logic [0:31] pc, input logic [0:15] imm,
                       input logic [0:31] ra, input logic [0:31] rt, input logic [0:6] rta,
                       input logic pt, input logic [0:31] ppc);
    bif.in_valid      = 1'b1;
    bif.in_op         = op;
    bif.in_pc         = pc;
    bif.in_imm        = imm;
    bif.in_ra         = ra;
    bif.in_rt         = rt;
    bif.in_rt_addr    = rta;
    bif.in_pred_taken = pt;
    bif.in_pred_pc    = ppc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    compared++;
    if (bif.PCout !== 66'd0 || bif.flush !== 1'b0 || bif.lnk_we !== 1'b0 || bif.lnk_addr !== 7'd0
        || bif.lnk_data !== 32'd0 || bif.br_count !== 6'd0 || bif.mp_count !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_state: PCout=%h flush=%b lnk_we=%b br=%0d mp=%0d, required all zero",
               bif.PCout, bif.flush, bif.lnk_we, bif.br_count, bif.mp_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_br_correct();
    issue(3'd0, 32'h100, 16'h0004, 32'd0, 32'd0, 7'd0, 1'b1, 32'h110);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h110, 1'b1, 32'h100, 1'b0} || bif.flush !== 1'b0) begin
      mismatched++;
      $display("FAIL br_correct: PCout=%h flush=%b required %h flush=0",
               bif.PCout, bif.flush, {32'h110, 1'b1, 32'h100, 1'b0});
    end
    compared++;
    if (bif.br_count !== 6'd1 || bif.mp_count !== 6'd0) begin
      mismatched++;
      $display("FAIL br_counts: br=%0d mp=%0d required br=1 mp=0", bif.br_count, bif.mp_count);
    end
    step();
    compared++;
    if (bif.PCout !== 66'd0 || bif.flush !== 1'b0 || bif.lnk_we !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_zero: PCout=%h flush=%b lnk_we=%b required 0", bif.PCout, bif.flush, bif.lnk_we);
    end
  endtask

  task automatic test_brz_mispredict();
    issue(3'd3, 32'h200, 16'h0010, 32'd0, 32'd5, 7'd0, 1'b1, 32'h300);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h204, 1'b0, 32'h200, 1'b1} || bif.flush !== 1'b1) begin
      mismatched++;
      $display("FAIL brz_mispredict: PCout=%h flush=%b required %h flush=1",
               bif.PCout, bif.flush, {32'h204, 1'b0, 32'h200, 1'b1});
    end
    compared++;
    if (bif.mp_count !== 6'd1 || bif.br_count !== 6'd2) begin
      mismatched++;
      $display("FAIL brz_counts: br=%0d mp=%0d required br=2 mp=1", bif.br_count, bif.mp_count);
    end
    step();
    compared++;
    if (bif.flush !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_pulse: flush=%b required 0", bif.flush);
    end
  endtask

  task automatic test_bi();
    issue(3'd2, 32'h400, 16'h0000, 32'h0004_1237, 32'd0, 7'd0, 1'b1, 32'h1234);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h1234, 1'b1, 32'h400, 1'b0} || bif.flush !== 1'b0) begin
      mismatched++;
      $display("FAIL bi_correct: PCout=%h flush=%b required %h", bif.PCout, bif.flush,
               {32'h1234, 1'b1, 32'h400, 1'b0});
    end
    step();
    issue(3'd2, 32'h400, 16'h0000, 32'h0004_1237, 32'd0, 7'd0, 1'b1, 32'h1238);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h1234, 1'b1, 32'h400, 1'b1} || bif.flush !== 1'b1) begin
      mismatched++;
      $display("FAIL bi_wrong_target: PCout=%h flush=%b required %h", bif.PCout, bif.flush,
               {32'h1234, 1'b1, 32'h400, 1'b1});
    end
    step();
  endtask

  task automatic test_other_ops();
    // BRHZ taken on zero low halfword, correctly predicted
    issue(3'd5, 32'h2000, 16'h0008, 32'd0, 32'hFFFF_0000, 7'd0, 1'b1, 32'h2020);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h2020, 1'b1, 32'h2000, 1'b0}) begin
      mismatched++;
      $display("FAIL brhz: PCout=%h required %h", bif.PCout, {32'h2020, 1'b1, 32'h2000, 1'b0});
    end
    // BRHNZ not taken, predicted not taken with junk pred_pc: correct
    issue(3'd6, 32'h2000, 16'h0008, 32'd0, 32'hFFFF_0000, 7'd0, 1'b0, 32'hDEAD);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h2004, 1'b0, 32'h2000, 1'b0} || bif.flush !== 1'b0) begin
      mismatched++;
      $display("FAIL brhnz: PCout=%h flush=%b required %h", bif.PCout, bif.flush,
               {32'h2004, 1'b0, 32'h2000, 1'b0});
    end
    // BRA with negative absolute address, masked
    issue(3'd1, 32'h3000, 16'h8000, 32'd0, 32'd0, 7'd0, 1'b1, 32'h0002_0000);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h0002_0000, 1'b1, 32'h3000, 1'b0}) begin
      mismatched++;
      $display("FAIL bra: PCout=%h required %h", bif.PCout, {32'h0002_0000, 1'b1, 32'h3000, 1'b0});
    end
    // pc=0, not taken, correct: word still nonzero via next_pc=4
    issue(3'd3, 32'h0, 16'h0040, 32'd0, 32'd1, 7'd0, 1'b0, 32'h0);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h4, 1'b0, 32'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL pc0_fallthru: PCout=%h required %h", bif.PCout, {32'h4, 1'b0, 32'h0, 1'b0});
    end
  endtask

  task automatic test_brsl();
    issue(3'd7, 32'h0003_FFFC, 16'hFFFF, 32'd0, 32'd0, 7'h00, 1'b1, 32'h0003_FFF8);
    step();
    idle();
    step();
    compared++;
    if (bif.PCout !== {32'h0003_FFF8, 1'b1, 32'h0003_FFFC, 1'b0}) begin
      mismatched++;
      $display("FAIL brsl_target: PCout=%h required %h", bif.PCout,
               {32'h0003_FFF8, 1'b1, 32'h0003_FFFC, 1'b0});
    end
    compared++;
    if (bif.lnk_we !== 1'b1 || bif.lnk_addr !== 7'h00 || bif.lnk_data !== 32'h0) begin
      mismatched++;
      $display("FAIL brsl_link_wrap: we=%b addr=%h data=%h required we=1 addr=00 data=0",
               bif.lnk_we, bif.lnk_addr, bif.lnk_data);
    end
    // mispredicted BRSL still writes its link register
    issue(3'd7, 32'h1000, 16'h0002, 32'd0, 32'd0, 7'h55, 1'b0, 32'h0);
    step();
    idle();
    step();
    compared++;
    if (bif.lnk_we !== 1'b1 || bif.lnk_addr !== 7'h55 || bif.lnk_data !== 32'h1004
        || bif.PCout !== {32'h1008, 1'b1, 32'h1000, 1'b1}) begin
      mismatched++;
      $display("FAIL brsl_mispredict_link: we=%b addr=%h data=%h PCout=%h required we=1 addr=55 data=1004",
               bif.lnk_we, bif.lnk_addr, bif.lnk_data, bif.PCout);
    end
    step();
    compared++;
    if (bif.lnk_we !== 1'b0) begin
      mismatched++;
      $display("FAIL lnk_we_pulse: lnk_we=%b required 0", bif.lnk_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:CNT_W-1] br0;
    br0 = bif.br_count;
    issue(3'd4, 32'h500, 16'h0040, 32'd0, 32'd0, 7'd0, 1'b1, 32'h600);   // N: mispredict
    step();
    issue(3'd0, 32'h600, 16'h0001, 32'd0, 32'd0, 7'd0, 1'b1, 32'h604);   // N+1
    step();
    compared++;
    if (bif.PCout !== {32'h504, 1'b0, 32'h500, 1'b1} || bif.flush !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_first: PCout=%h flush=%b required %h flush=1", bif.PCout, bif.flush,
               {32'h504, 1'b0, 32'h500, 1'b1});
    end
    issue(3'd0, 32'h700, 16'h0001, 32'd0, 32'd0, 7'd0, 1'b1, 32'h704);   // N+2
    step();
    compared++;
    if (bif.PCout !== 66'd0 || bif.flush !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_killed_n1: PCout=%h flush=%b required 0", bif.PCout, bif.flush);
    end
    issue(3'd0, 32'h800, 16'h0001, 32'd0, 32'd0, 7'd0, 1'b1, 32'h804);   // N+3
    step();
    idle();
    compared++;
    if (bif.PCout !== 66'd0) begin
      mismatched++;
      $display("FAIL b2b_dropped_n2: PCout=%h required 0", bif.PCout);
    end
    step();
    compared++;
    if (bif.PCout !== {32'h804, 1'b1, 32'h800, 1'b0}) begin
      mismatched++;
      $display("FAIL b2b_n3: PCout=%h required %h", bif.PCout, {32'h804, 1'b1, 32'h800, 1'b0});
    end
    compared++;
    if (bif.br_count - br0 !== CNT_W'(2)) begin
      mismatched++;
      $display("FAIL b2b_count: delta=%0d required 2", bif.br_count - br0);
    end
    step();
  endtask

  task automatic test_saturate_and_reset();
    logic [0:31] exp_pc;
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) issue(3'd0, 32'h1000 + 32'(i) * 32'd16, 16'h0000, 32'd0, 32'd0, 7'd0, 1'b1,
                        32'h1000 + 32'(i) * 32'd16);
      else idle();
      step();
      if (i >= 1) begin
        exp_pc = 32'h1000 + 32'(i - 1) * 32'd16;
        compared++;
        if (bif.PCout !== {exp_pc, 1'b1, exp_pc, 1'b0}) begin
          mismatched++;
          $display("FAIL throughput_%0d: PCout=%h required %h", i, bif.PCout, {exp_pc, 1'b1, exp_pc, 1'b0});
        end
      end
    end
    compared++;
    if (bif.br_count !== 6'h3F) begin
      mismatched++;
      $display("FAIL br_saturate: br=%0d required 63", bif.br_count);
    end
    for (int i = 0; i < 64; i++) begin
      issue(3'd3, 32'h4000, 16'h0004, 32'd0, 32'd1, 7'd0, 1'b1, 32'h4010);
      step();
      idle();
      step();
      step();
    end
    compared++;
    if (bif.mp_count !== 6'h3F || bif.br_count !== 6'h3F) begin
      mismatched++;
      $display("FAIL mp_saturate: mp=%0d br=%0d required 63/63", bif.mp_count, bif.br_count);
    end
    // reset while a branch sits in E1
    issue(3'd7, 32'h5000, 16'h0001, 32'd0, 32'd0, 7'h12, 1'b1, 32'h5004);
    step();
    idle();
    reset = 1'b1;
    step();
    compared++;
    if (bif.PCout !== 66'd0 || bif.lnk_we !== 1'b0 || bif.br_count !== 6'd0 || bif.mp_count !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_midflight: PCout=%h lnk_we=%b br=%0d mp=%0d required all zero",
               bif.PCout, bif.lnk_we, bif.br_count, bif.mp_count);
    end
    reset = 1'b0;
    step();
    step();
    compared++;
    if (bif.PCout !== 66'd0 || bif.lnk_we !== 1'b0 || bif.br_count !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_no_ghost: PCout=%h lnk_we=%b br=%0d required zero",
               bif.PCout, bif.lnk_we, bif.br_count);
    end
  endtask

  initial begin
    test_reset();
    test_br_correct();
    test_brz_mispredict();
    test_bi();
    test_other_ops();
    test_brsl();
    test_back_to_back();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Odd-pipe branch resolution unit for the SPU. Accepts issued branch instructions together with the prediction that fetch made, evaluates condition and target over a two-stage pipeline, and drives the 66-bit branch feedback word consumed by fetch/predictor update, plus the decode flush and link-register write. Sits inside the processing unit on the odd pipe, after operand read.

## Interface
- LSLR, 32'h0003_FFFC — local-store limit mask applied to every computed target and fall-through PC.
- CNT_W, 16 — width of the saturating statistics counters.
- clk  input  1 — single clock.
- reset  input  1 — synchronous, active-high.
- in_valid  input  1 — branch issued this cycle.
- in_op  input  [0:2] — 0 BR, 1 BRA, 2 BI, 3 BRZ, 4 BRNZ, 5 BRHZ, 6 BRHNZ, 7 BRSL.
- in_pc  input  [0:31] — branch address.
- in_imm  input  [0:15] — I16 word offset (BR/BRZ/BRNZ/BRHZ/BRHNZ/BRSL) or absolute word address (BRA).
- in_ra  input  [0:31] — preferred word of RA (BI target).
- in_rt  input  [0:31] — preferred word of RT (condition operand).
- in_rt_addr  input  [0:6] — RT register number (BRSL link destination).
- in_pred_taken  input  1 — fetch prediction.
- in_pred_pc  input  [0:31] — predicted next PC.
- PCout  output  [0:65] — [0:31] correct next PC, [32] taken, [33:64] branch PC, [65] mispredict; all zero when no resolution this cycle.
- flush  output  1 — squash younger instructions in decode/issue.
- lnk_we  output  1 — link write strobe.
- lnk_addr  output  [0:6] — link destination.
- lnk_data  output  [0:31] — (pc+4) & LSLR.
- br_count, mp_count  output  [0:CNT_W-1] — resolved branches, mispredicts; saturating.

## Operation
- E1: register valid, op, pc, imm, ra, rt, rt_addr, prediction. E2: compute, compare, register outputs.
- Targets: relative = (pc + (sext(imm) << 2)) & LSLR; BRA = (sext(imm) << 2) & LSLR; BI = ra & LSLR (low 2 bits forced 0 by LSLR). Fall-through = (pc + 4) & LSLR, 32-bit wrap.
- Taken: BR, BRA, BI, BRSL always; BRZ rt==0; BRNZ rt!=0; BRHZ rt[16:31]==0; BRHNZ rt[16:31]!=0.
- next_pc = taken ? target : fall-through.
- mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_pc). A not-taken branch predicted not-taken is correct regardless of pred_pc.
- Output cycle: PCout = {next_pc, taken, pc, mispredict}; flush = mispredict. PCout is nonzero on every resolution (pc field or bit 32/65 nonzero; a resolution of pc=0, not-taken, correct still carries next_pc=4).
- BRSL: lnk_we=1, lnk_addr=rt_addr, lnk_data=fall-through, in the output cycle, regardless of mispredict.
- Squash: when E2 resolves a mispredict, the E1 entry is invalidated (not resolved, no counters, no link write); an in_valid asserted in the same cycle as flush is discarded.
- Counters: br_count +1 per resolution, mp_count +1 per mispredict; hold at all-ones.

## Timing
- Latency: in_valid at cycle N -> PCout/flush/lnk_* at N+2 (registered); one branch per cycle throughput.
- flush is a one-cycle pulse aligned with the mispredicting PCout word.
- Back-to-back: mispredict at N+2 kills the branch issued at N+1; branch issued at N+2 (flush cycle) also dropped; branch issued at N+3 proceeds.
- Reset: PCout=0, flush=0, lnk_we=0, lnk_addr=0, lnk_data=0, counters=0, pipeline valids cleared; reset mid-flight drops all in-flight branches with no output.
- Idle cycles: all single-cycle outputs return to 0.

## Test plan
- BR pc=0x100 imm=0x0004, pred taken pc=0x110 -> N+2 PCout={0x110,1,0x100,0}, flush=0, br_count=1.
- BRZ pc=0x200 rt=5, pred taken 0x300 -> PCout={0x204,0,0x200,1}, flush=1, mp_count=1.
- BI ra=0x0004_1237, pred taken 0x1234 -> target 0x1234 masked, no mispredict; repeat with pred 0x1238 -> mispredict, next_pc=0x1234.
- BRSL pc=0x3FFFC, rt_addr=0x00, imm=-1 -> lnk_we=1, lnk_data=0x0 (wrap), target 0x3FFF8.
- Mispredicting BRNZ at N, correct BR at N+1, BR at N+2, BR at N+3 -> only N and N+3 resolve; br_count=2.
- Preload counters near all-ones via 2^CNT_W resolutions -> saturate; assert reset mid-stream -> all outputs 0 next cycle, in-flight branch never appears.
